// File: rtl/kanagawa_ram_read_stream.sv
// Burst read engine: turns {addr, len} commands into RAM reads and returns the words as a
// valid/ready stream with a last flag. Optional stall counter under KANAGAWA_RAM_READ_STREAM_STATS_EN.
module kanagawa_ram_read_stream #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid_in,
  output logic                  cmd_ready_out,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_in,
  input  logic [ADDR_WIDTH-1:0] cmd_len_in,
  output logic [ADDR_WIDTH-1:0] ram_readaddr_out,
  input  logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] out_data_out,
  output logic                  out_last_out,
  output logic                  busy_out
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
  , output logic [31:0]         stall_count_out
`endif
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 2;

  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;

  logic [ADDR_WIDTH-1:0] addr_q, remain_q;
  logic                  accept, issue, issue_last, credit_ok, push, pop;
  logic [READ_LATENCY:1] vld_pipe, last_pipe;
  logic [CW-1:0]         inflight_q, fifo_cnt_q;
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_last;

  // Every read in flight already owns a FIFO slot, so the tail can always be written.
  assign credit_ok = (inflight_q + fifo_cnt_q) < CW'(FIFO_DEPTH);

  always_comb begin
    state_d       = state_q;
    cmd_ready_out = 1'b0;
    accept        = 1'b0;
    issue         = 1'b0;
    issue_last    = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready_out = 1'b1;
        if (cmd_valid_in) begin
          accept  = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        issue      = credit_ok;
        issue_last = credit_ok && (remain_q == '0);
        if (issue_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      remain_q <= '0;
    end else if (accept) begin
      addr_q   <= cmd_addr_in;
      remain_q <= cmd_len_in;
    end else if (issue) begin
      addr_q <= addr_q + 1'b1;
      if (remain_q != '0) remain_q <= remain_q - 1'b1;
    end
  end

  assign ram_readaddr_out = addr_q;

  // Tag pipeline mirrors the RAM latency; the tail marks the cycle ram_data_in is valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe[1]  <= issue;
      last_pipe[1] <= issue_last;
      for (int i = 2; i <= READ_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
    end
  end

  assign push = vld_pipe[READ_LATENCY];
  assign pop  = out_valid_out && out_ready_in;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= '0;
      fifo_cnt_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      inflight_q <= inflight_q + CW'(issue) - CW'(push);
      fifo_cnt_q <= fifo_cnt_q + CW'(push) - CW'(pop);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr_q] <= ram_data_in;
      fifo_last[wr_ptr_q] <= last_pipe[READ_LATENCY];
    end
  end

  // Storage is never reset, so the head is masked while the FIFO is empty.
  assign out_valid_out = (fifo_cnt_q != '0);
  assign out_data_out  = out_valid_out ? fifo_data[rd_ptr_q] : '0;
  assign out_last_out  = out_valid_out & fifo_last[rd_ptr_q];
  assign busy_out      = (state_q == BURST) || (inflight_q != '0) || out_valid_out;

`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_count_out <= '0;
    else if (state_q == BURST && !issue && stall_count_out != '1)
      stall_count_out <= stall_count_out + 1'b1;
  end
`endif

endmodule

// File: tb/tb_kanagawa_ram_read_stream.sv
// Directed bench for kanagawa_ram_read_stream with a behavioural fixed-latency RAM model.
module tb_kanagawa_ram_read_stream;
  localparam int DW = 32;
  localparam int AW = 9;
  localparam int L  = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid_in, cmd_ready_out;
  logic [AW-1:0] cmd_addr_in, cmd_len_in, ram_readaddr_out;
  logic [DW-1:0] ram_data_in, out_data_out;
  logic          out_valid_out, out_ready_in, out_last_out, busy_out;
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
  logic [31:0]   stall_count_out;
`endif

  kanagawa_ram_read_stream #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .READ_LATENCY(L), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid_in(cmd_valid_in), .cmd_ready_out(cmd_ready_out),
    .cmd_addr_in(cmd_addr_in), .cmd_len_in(cmd_len_in),
    .ram_readaddr_out(ram_readaddr_out), .ram_data_in(ram_data_in),
    .out_valid_out(out_valid_out), .out_ready_in(out_ready_in),
    .out_data_out(out_data_out), .out_last_out(out_last_out),
    .busy_out(busy_out)
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    , .stall_count_out(stall_count_out)
`endif
  );

  always #5 clk = ~clk;

  // RAM model: address sampled at an edge, data appears L edges later
  logic [DW-1:0] mem   [0:(1<<AW)-1];
  logic [DW-1:0] rpipe [0:L-1];
  always @(posedge clk) begin
    rpipe[0] <= mem[ram_readaddr_out];
    for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
  end
  assign ram_data_in = rpipe[L-1];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] gd[$];
  logic          gl[$];
  int            gc[$];

  task automatic send_cmd(input logic [AW-1:0] a, input logic [AW-1:0] l, output int acc);
    int t = 0;
    cmd_valid_in = 1'b1;
    cmd_addr_in  = a;
    cmd_len_in   = l;
    while (!cmd_ready_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (!cmd_ready_out) begin
      failures++;
      $display("FAIL cmd_accept_timeout addr=%0d got ready=%b want 1", a, cmd_ready_out);
    end
    acc = cyc;
    @(negedge clk);
    cmd_valid_in = 1'b0;
  endtask

  task automatic collect(input int n, input bit toggle);
    int t = 0;
    bit r = 1'b1;
    logic pv = 1'b0;
    logic [DW-1:0] pd = '0;
    logic pl = 1'b0;
    gd.delete(); gl.delete(); gc.delete();
    while (gd.size() < n && t < 400) begin
      @(negedge clk);
      t++;
      if (pv) begin
        checks++;
        if (out_valid_out !== 1'b1 || out_data_out !== pd || out_last_out !== pl) begin
          failures++;
          $display("FAIL hold_stable got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   out_valid_out, out_data_out, out_last_out, pd, pl);
        end
      end
      out_ready_in = toggle ? r : 1'b1;
      r  = !r;
      pv = out_valid_out && !out_ready_in;
      pd = out_data_out;
      pl = out_last_out;
      if (out_valid_out && out_ready_in) begin
        gd.push_back(out_data_out);
        gl.push_back(out_last_out);
        gc.push_back(cyc);
      end
    end
    checks++;
    if (gd.size() < n) begin
      failures++;
      $display("FAIL collect_timeout got %0d words want %0d", gd.size(), n);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    out_ready_in = 1'b1;
    @(negedge clk);
    while (busy_out && t < 100) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (busy_out !== 1'b0) begin
      failures++;
      $display("FAIL idle_timeout got busy=%b want 0", busy_out);
    end
  endtask

  task automatic check_words(input string nm, input logic [DW-1:0] exp_d[$], input logic exp_l[$]);
    for (int i = 0; i < exp_d.size(); i++) begin
      checks++;
      if (i >= gd.size() || gd[i] !== exp_d[i] || gl[i] !== exp_l[i]) begin
        failures++;
        $display("FAIL %s_word%0d got d=%h l=%b want d=%h l=%b", nm, i,
                 (i < gd.size()) ? gd[i] : 'x, (i < gl.size()) ? gl[i] : 1'bx, exp_d[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks += 6;
    if (cmd_ready_out !== 1'b1)  begin failures++; $display("FAIL rst_cmd_ready got %b want 1", cmd_ready_out); end
    if (out_valid_out !== 1'b0)  begin failures++; $display("FAIL rst_out_valid got %b want 0", out_valid_out); end
    if (out_last_out !== 1'b0)   begin failures++; $display("FAIL rst_out_last got %b want 0", out_last_out); end
    if (out_data_out !== '0)     begin failures++; $display("FAIL rst_out_data got %h want 0", out_data_out); end
    if (ram_readaddr_out !== '0) begin failures++; $display("FAIL rst_readaddr got %h want 0", ram_readaddr_out); end
    if (busy_out !== 1'b0)       begin failures++; $display("FAIL rst_busy got %b want 0", busy_out); end
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    checks++;
    if (stall_count_out !== 32'd0) begin failures++; $display("FAIL rst_stall got %0d want 0", stall_count_out); end
`endif
  endtask

  task automatic test_single();
    mem[5] = 32'hA5A5;
    out_ready_in = 1'b1;
    cmd_valid_in = 1'b1;
    cmd_addr_in  = 9'd5;
    cmd_len_in   = 9'd0;
    checks++;
    if (cmd_ready_out !== 1'b1) begin failures++; $display("FAIL single_ready got %b want 1", cmd_ready_out); end
    @(negedge clk);  // cycle k+1
    cmd_valid_in = 1'b0;
    checks += 4;
    if (ram_readaddr_out !== 9'd5) begin failures++; $display("FAIL single_addr got %0d want 5", ram_readaddr_out); end
    if (cmd_ready_out !== 1'b0)    begin failures++; $display("FAIL single_burst_ready got %b want 0", cmd_ready_out); end
    if (busy_out !== 1'b1)         begin failures++; $display("FAIL single_busy got %b want 1", busy_out); end
    if (out_valid_out !== 1'b0)    begin failures++; $display("FAIL single_v1 got %b want 0", out_valid_out); end
    @(negedge clk);  // k+2
    checks += 2;
    if (out_valid_out !== 1'b0) begin failures++; $display("FAIL single_v2 got %b want 0", out_valid_out); end
    if (cmd_ready_out !== 1'b1) begin failures++; $display("FAIL single_idle_ready got %b want 1", cmd_ready_out); end
    @(negedge clk);  // k+3
    checks++;
    if (out_valid_out !== 1'b0) begin failures++; $display("FAIL single_v3 got %b want 0", out_valid_out); end
    @(negedge clk);  // k+4
    checks++;
    if (out_valid_out !== 1'b1 || out_data_out !== 32'hA5A5 || out_last_out !== 1'b1) begin
      failures++;
      $display("FAIL single_word got v=%b d=%h l=%b want v=1 d=0000a5a5 l=1", out_valid_out, out_data_out, out_last_out);
    end
    @(negedge clk);  // k+5
    checks++;
    if (busy_out !== 1'b0 || out_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL single_done got busy=%b v=%b want 0 0", busy_out, out_valid_out);
    end
    mem[5] = 32'd5;
  endtask

  task automatic test_stream();
    logic [DW-1:0] ed[$];
    logic el[$];
    int acc;
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    logic [31:0] s0 = stall_count_out;
`endif
    for (int i = 0; i < 16; i++) begin ed.push_back(DW'(i)); el.push_back(i == 15); end
    @(negedge clk);
    fork
      send_cmd(9'd0, 9'd15, acc);
      collect(16, 1'b0);
    join
    check_words("stream", ed, el);
    for (int i = 1; i < gc.size(); i++) begin
      checks++;
      if (gc[i] - gc[i-1] != 1) begin
        failures++;
        $display("FAIL stream_bubble idx=%0d got gap=%0d want 1", i, gc[i] - gc[i-1]);
      end
    end
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    checks++;
    if (stall_count_out !== s0) begin failures++; $display("FAIL stream_stall got %0d want %0d", stall_count_out, s0); end
`endif
    wait_idle();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] ed[$];
    logic el[$];
    int acc;
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    logic [31:0] s0 = stall_count_out;
`endif
    for (int i = 0; i < 8; i++) begin ed.push_back(DW'(10 + i)); el.push_back(i == 7); end
    @(negedge clk);
    fork
      send_cmd(9'd10, 9'd7, acc);
      collect(8, 1'b1);
    join
    check_words("bp", ed, el);
`ifdef KANAGAWA_RAM_READ_STREAM_STATS_EN
    checks++;
    if (stall_count_out <= s0) begin failures++; $display("FAIL bp_stall got %0d want >%0d", stall_count_out, s0); end
`endif
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_out !== 1'b0) begin failures++; $display("FAIL bp_extra_word got v=%b want 0", out_valid_out); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] ed[$] = '{32'd510, 32'd511, 32'd0, 32'd1};
    logic el[$] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int acc;
    @(negedge clk);
    fork
      send_cmd(9'd510, 9'd3, acc);
      collect(4, 1'b0);
    join
    check_words("wrap", ed, el);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] ed[$] = '{32'd0, 32'd1, 32'd2, 32'd100, 32'd101};
    logic el[$] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int acc_a, acc_b;
    @(negedge clk);
    fork
      begin
        send_cmd(9'd0, 9'd2, acc_a);
        send_cmd(9'd100, 9'd1, acc_b);
      end
      collect(5, 1'b0);
    join
    check_words("b2b", ed, el);
    checks++;
    if (acc_b - acc_a != 4) begin
      failures++;
      $display("FAIL b2b_accept_gap got %0d want 4", acc_b - acc_a);
    end
    wait_idle();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] ed[$] = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    logic el[$] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [DW-1:0] e3[$] = '{32'd3};
    logic l3[$] = '{1'b1};
    int acc;
    int stale = 0;
    @(negedge clk);
    fork
      send_cmd(9'd0, 9'd31, acc);
      collect(6, 1'b0);
    join
    check_words("rstmid", ed, el);
    @(negedge clk);
    out_ready_in = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks += 3;
    if (out_valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_valid got %b want 0", out_valid_out); end
    if (busy_out !== 1'b0)      begin failures++; $display("FAIL rstmid_busy got %b want 0", busy_out); end
    if (cmd_ready_out !== 1'b1) begin failures++; $display("FAIL rstmid_ready got %b want 1", cmd_ready_out); end
    out_ready_in = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (out_valid_out) stale++;
    end
    checks++;
    if (stale != 0) begin failures++; $display("FAIL rstmid_stale got %0d valid cycles want 0", stale); end
    fork
      send_cmd(9'd3, 9'd0, acc);
      collect(1, 1'b0);
    join
    check_words("rstmid_new", e3, l3);
    wait_idle();
    repeat (3) @(negedge clk);
    checks++;
    if (out_valid_out !== 1'b0) begin failures++; $display("FAIL rstmid_extra got v=%b want 0", out_valid_out); end
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    rst          = 1'b1;
    cmd_valid_in = 1'b0;
    cmd_addr_in  = '0;
    cmd_len_in   = '0;
    out_ready_in = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got time=%0t want completion", $time);
    $fatal(1, "timeout");
  end
endmodule
